// File: rtl/isa_pkg.sv
// Shared ISA definitions for the issue scheduler: opcode nibbles, register file
// geometry, controller states and the per-op result latency lookup.
package isa_pkg;
  localparam int NIB_W    = 4;
  localparam int NUM_REGS = 8;
  localparam int REG_W    = 3;
  localparam int LAT_W    = 3;

  localparam logic [NIB_W-1:0] OP_ADD = 4'd0;
  localparam logic [NIB_W-1:0] OP_SUB = 4'd1;
  localparam logic [NIB_W-1:0] OP_MUL = 4'd2;
  localparam logic [NIB_W-1:0] OP_DIV = 4'd3;
  localparam logic [NIB_W-1:0] OP_END = 4'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_F_OP, S_F_RD, S_F_RS1, S_F_RS2, S_CHECK, S_ISSUE, S_DRAIN, S_DONE
  } state_t;

  function automatic logic [LAT_W-1:0] op_latency(input logic [1:0] op,
                                                  input int lat_add,
                                                  input int lat_mul,
                                                  input int lat_div);
    case ({2'b00, op})
      OP_MUL:  return LAT_W'(lat_mul);
      OP_DIV:  return LAT_W'(lat_div);
      default: return LAT_W'(lat_add);
    endcase
  endfunction
endpackage

// File: rtl/issue_scheduler_if.sv
// Issue port between the scheduler (master) and the execution unit (slave).
interface issue_scheduler_if;
  import isa_pkg::*;

  // A transfer happens on a rising edge where issue_valid && issue_ready; the
  // master holds valid and all fields stable until then, ready may toggle freely.
  logic             issue_valid;
  logic             issue_ready;
  logic [1:0]       issue_op;
  logic [REG_W-1:0] issue_rd;
  logic [REG_W-1:0] issue_rs1;
  logic [REG_W-1:0] issue_rs2;

  modport master (output issue_valid, issue_op, issue_rd, issue_rs1, issue_rs2,
                  input  issue_ready);
  modport slave  (input  issue_valid, issue_op, issue_rd, issue_rs1, issue_rs2,
                  output issue_ready);
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register result countdowns; a register is busy while its count is nonzero.
module reg_scoreboard
  import isa_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en,
  input  logic [REG_W-1:0]    set_idx,
  input  logic [LAT_W-1:0]    set_lat,
  output logic [NUM_REGS-1:0] busy,
  output logic                all_idle
);
  logic [LAT_W-1:0] r_cnt [NUM_REGS];

  // A new issue to a register replaces its countdown instead of decrementing it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (set_en && (set_idx == REG_W'(i))) r_cnt[i] <= set_lat;
        else if (r_cnt[i] != '0)              r_cnt[i] <= r_cnt[i] - LAT_W'(1);
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_REGS; i++) busy[i] = (r_cnt[i] != '0);
  end

  assign all_idle = ~|busy;
endmodule

// File: rtl/issue_scheduler.sv
// In-order issue controller: fetches 4-nibble instructions, stalls on RAW/WAW
// hazards against the register scoreboard and hands instructions to execution.
module issue_scheduler
  import isa_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int PROG_BASE = 8,
  parameter int LAT_ADD   = 1,
  parameter int LAT_MUL   = 3,
  parameter int LAT_DIV   = 6,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [NIB_W-1:0]   mem_data,
  issue_scheduler_if.master  iss,
  output logic [CNT_W-1:0]   raw_stalls,
  output logic [CNT_W-1:0]   waw_stalls,
  output logic [CNT_W-1:0]   instr_count,
  output logic               busy,
  output logic               done,
  output logic               err,
  output state_t             o_state
);
  state_t             r_state, w_state;
  logic [ADDR_W-1:0]  r_mem_addr, w_mem_addr;
  logic [ADDR_W:0]    w_addr_inc;
  logic               w_addr_ovf;
  logic [1:0]         r_op, w_op;
  logic [REG_W-1:0]   r_rd, w_rd, r_rs1, w_rs1, r_rs2, w_rs2;
  logic               r_valid, w_valid;
  logic [CNT_W-1:0]   r_raw, w_raw, r_waw, w_waw, r_icnt, w_icnt;
  logic               r_done, w_done, r_err, w_err;
  logic [NUM_REGS-1:0] w_busy;
  logic               w_all_idle, w_set_en, w_raw_hz, w_waw_hz;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_addr_inc = {1'b0, r_mem_addr} + {{ADDR_W{1'b0}}, 1'b1};
  assign w_addr_ovf = w_addr_inc[ADDR_W];
  assign w_raw_hz   = w_busy[r_rs1] | w_busy[r_rs2];
  assign w_waw_hz   = w_busy[r_rd];

  reg_scoreboard u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (w_set_en),
    .set_idx  (r_rd),
    .set_lat  (op_latency(r_op, LAT_ADD, LAT_MUL, LAT_DIV)),
    .busy     (w_busy),
    .all_idle (w_all_idle)
  );

  always_comb begin
    w_state    = r_state;
    w_mem_addr = r_mem_addr;
    w_op       = r_op;
    w_rd       = r_rd;
    w_rs1      = r_rs1;
    w_rs2      = r_rs2;
    w_valid    = r_valid;
    w_raw      = r_raw;
    w_waw      = r_waw;
    w_icnt     = r_icnt;
    w_done     = r_done;
    w_err      = r_err;
    w_set_en   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: if (start) begin
        w_mem_addr = ADDR_W'(PROG_BASE);
        w_raw      = '0;
        w_waw      = '0;
        w_icnt     = '0;
        w_done     = 1'b0;
        w_err      = 1'b0;
        w_state    = S_F_OP;
      end
      S_F_OP: begin
        if (mem_data == OP_END) begin
          w_state = S_DRAIN;
        end else if (mem_data > OP_END || w_addr_ovf) begin
          w_err   = 1'b1;
          w_state = S_DONE;
        end else begin
          w_op       = mem_data[1:0];
          w_mem_addr = w_addr_inc[ADDR_W-1:0];
          w_state    = S_F_RD;
        end
      end
      S_F_RD, S_F_RS1: begin
        if (mem_data[NIB_W-1] || w_addr_ovf) begin
          w_err   = 1'b1;
          w_state = S_DONE;
        end else begin
          if (r_state == S_F_RD) w_rd = mem_data[REG_W-1:0];
          else                   w_rs1 = mem_data[REG_W-1:0];
          w_mem_addr = w_addr_inc[ADDR_W-1:0];
          w_state    = (r_state == S_F_RD) ? S_F_RS1 : S_F_RS2;
        end
      end
      // The rs2 address is held until the handshake, which advances to the next opcode.
      S_F_RS2: begin
        if (mem_data[NIB_W-1]) begin
          w_err   = 1'b1;
          w_state = S_DONE;
        end else begin
          w_rs2   = mem_data[REG_W-1:0];
          w_state = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_raw_hz || w_waw_hz) begin
          if (w_raw_hz) w_raw = sat_inc(r_raw);
          if (w_waw_hz) w_waw = sat_inc(r_waw);
        end else begin
          w_valid = 1'b1;
          w_state = S_ISSUE;
        end
      end
      S_ISSUE: if (iss.issue_ready) begin
        w_valid  = 1'b0;
        w_set_en = 1'b1;
        w_icnt   = sat_inc(r_icnt);
        if (w_addr_ovf) begin
          w_err   = 1'b1;
          w_state = S_DONE;
        end else begin
          w_mem_addr = w_addr_inc[ADDR_W-1:0];
          w_state    = S_F_OP;
        end
      end
      S_DRAIN: if (w_all_idle) begin
        w_done  = 1'b1;
        w_state = S_DONE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_mem_addr <= ADDR_W'(PROG_BASE);
      r_op       <= '0;
      r_rd       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_valid    <= 1'b0;
      r_raw      <= '0;
      r_waw      <= '0;
      r_icnt     <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_mem_addr <= w_mem_addr;
      r_op       <= w_op;
      r_rd       <= w_rd;
      r_rs1      <= w_rs1;
      r_rs2      <= w_rs2;
      r_valid    <= w_valid;
      r_raw      <= w_raw;
      r_waw      <= w_waw;
      r_icnt     <= w_icnt;
      r_done     <= w_done;
      r_err      <= w_err;
    end
  end

  assign mem_addr        = r_mem_addr;
  assign iss.issue_valid = r_valid;
  assign iss.issue_op    = r_op;
  assign iss.issue_rd    = r_rd;
  assign iss.issue_rs1   = r_rs1;
  assign iss.issue_rs2   = r_rs2;
  assign raw_stalls      = r_raw;
  assign waw_stalls      = r_waw;
  assign instr_count     = r_icnt;
  assign busy            = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done            = r_done;
  assign err             = r_err;
  assign o_state         = r_state;
endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: a table of whole-program vectors plus
// hand sequences for issue timing, back-pressure, drain, error restart and reset.
module tb_issue_scheduler;
  import isa_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  mem_addr;
  logic [3:0]  mem_data;
  logic [15:0] raw_stalls, waw_stalls, instr_count;
  logic        busy, done, err;
  state_t      st;
  logic [3:0]  mem [64];

  issue_scheduler_if u_if ();

  issue_scheduler u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_addr(mem_addr), .mem_data(mem_data), .iss(u_if),
    .raw_stalls(raw_stalls), .waw_stalls(waw_stalls), .instr_count(instr_count),
    .busy(busy), .done(done), .err(err), .o_state(st)
  );

  assign mem_data = mem[mem_addr];

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  int n_checks = 0;
  int n_err = 0;
  logic [10:0] exp_q[$];
  int hs_q[$];
  int rise_q[$];
  int done_edge = 0;
  int drain_cyc = 0;
  int drain_done_hi = 0;
  logic prev_valid = 1'b0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (u_if.issue_valid && !prev_valid) rise_q.push_back(cyc);
      prev_valid = u_if.issue_valid;
      if (u_if.issue_valid && u_if.issue_ready) begin
        hs_q.push_back(cyc + 1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL issue_unexpected: got %0h expected none",
                   {u_if.issue_op, u_if.issue_rd, u_if.issue_rs1, u_if.issue_rs2});
        end else begin
          chk("issue_fields", {21'd0, u_if.issue_op, u_if.issue_rd, u_if.issue_rs1,
              u_if.issue_rs2}, {21'd0, exp_q.pop_front()});
        end
      end
      if (st == S_DRAIN) begin
        drain_cyc++;
        if (done) drain_done_hi++;
      end
      if (done && !prev_done) done_edge = cyc;
      prev_done = done;
    end else begin
      prev_valid = 1'b0;
      prev_done  = 1'b0;
    end
  end

  // driver tasks
  function automatic logic [15:0] ins(input int op, input int rd, input int rs1, input int rs2);
    return {4'(rs2), 4'(rs1), 4'(rd), 4'(op)};
  endfunction

  task automatic load_prog(input logic [63:0] prog, input int n_iss);
    logic [15:0] t;
    for (int i = 0; i < 64; i++) mem[i] = 4'h4;
    for (int i = 0; i < 16; i++) mem[8 + i] = prog[4*i +: 4];
    for (int k = 0; k < n_iss; k++) begin
      t = prog[16*k +: 16];
      exp_q.push_back({t[1:0], t[6:4], t[10:8], t[14:12]});
    end
    hs_q.delete();
    rise_q.delete();
    drain_cyc = 0;
    drain_done_hi = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int k = 0;
    @(negedge clk);
    while (!(done || err) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("run_end", 32'(done | err), 1);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"}, 32'(mem_addr), 8);
    chk({tag, "_valid"}, 32'(u_if.issue_valid), 0);
    chk({tag, "_fields"}, {21'd0, u_if.issue_op, u_if.issue_rd, u_if.issue_rs1, u_if.issue_rs2}, 0);
    chk({tag, "_stalls"}, {raw_stalls, waw_stalls}, 0);
    chk({tag, "_icnt"}, 32'(instr_count), 0);
    chk({tag, "_flags"}, {29'd0, busy, done, err}, 0);
    chk({tag, "_state"}, 32'(st), 32'(S_IDLE));
  endtask

  typedef struct {
    string       name;
    logic [63:0] prog;
    int          n_iss;
    int          raw;
    int          waw;
    logic        done;
    logic        err;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input string name, input logic [63:0] prog, input int n_iss,
                              input int raw, input int waw, input logic dn, input logic er);
    vec_t v;
    v.name = name; v.prog = prog; v.n_iss = n_iss;
    v.raw = raw; v.waw = waw; v.done = dn; v.err = er;
    return v;
  endfunction

  initial begin
    logic [63:0] p_raw, p_waw, p_bad;
    vq.push_back(mk("add_sub", {32'h44444444, ins(1,4,1,5), ins(0,1,2,3)}, 2, 0, 0, 1, 0));
    vq.push_back(mk("div_raw", {32'h44444444, ins(0,4,1,1), ins(3,1,2,3)}, 2, 2, 0, 1, 0));
    vq.push_back(mk("div_waw", {32'h44444444, ins(2,1,4,5), ins(3,1,2,3)}, 2, 0, 2, 1, 0));
    vq.push_back(mk("raw_waw", {32'h44444444, ins(3,7,7,6), ins(3,7,0,0)}, 2, 2, 2, 1, 0));
    vq.push_back(mk("no_stall3", {16'h4444, ins(0,5,1,6), ins(0,2,3,4), ins(3,1,2,3)}, 3, 0, 0, 1, 0));
    vq.push_back(mk("end_only", 64'h4444444444444444, 0, 0, 0, 1, 0));
    vq.push_back(mk("bad_op", {48'h444444444444, ins(9,0,0,0)}, 0, 0, 0, 0, 1));
    vq.push_back(mk("bad_rd", {48'h444444444444, ins(0,8,0,0)}, 0, 0, 0, 0, 1));
    vq.push_back(mk("bad_rs2", {32'h44444444, ins(1,2,3,15), ins(0,1,2,3)}, 1, 0, 0, 0, 1));

    u_if.issue_ready = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = 4'h4;
    repeat (3) @(posedge clk);
    #1 chk_reset("reset");
    @(negedge clk) rst_n = 1'b1;

    // table-driven programs
    foreach (vq[i]) begin
      load_prog(vq[i].prog, vq[i].n_iss);
      pulse_start();
      wait_end(300);
      chk({vq[i].name, "_raw"}, 32'(raw_stalls), vq[i].raw);
      chk({vq[i].name, "_waw"}, 32'(waw_stalls), vq[i].waw);
      chk({vq[i].name, "_icnt"}, 32'(instr_count), vq[i].n_iss);
      chk({vq[i].name, "_done_err"}, {30'd0, done, err}, {30'd0, vq[i].done, vq[i].err});
      chk({vq[i].name, "_state"}, 32'(st), 32'(S_DONE));
      chk({vq[i].name, "_pending"}, 32'(exp_q.size()), 0);
      exp_q.delete();
    end

    // RAW stall timing: second valid seven edges after the first handshake
    p_raw = {32'h44444444, ins(0,4,1,1), ins(3,1,2,3)};
    load_prog(p_raw, 2);
    pulse_start();
    wait_end(300);
    chk("raw_issue_gap", 32'(rise_q[1] - hs_q[0]), 7);

    // WAW then drain: done stays low for the three cycles cnt[1] needs
    p_waw = {32'h44444444, ins(2,1,4,5), ins(3,1,2,3)};
    load_prog(p_waw, 2);
    pulse_start();
    wait_end(300);
    chk("drain_cycles", 32'(drain_cyc), 3);
    chk("drain_done_low", 32'(drain_done_hi), 0);
    chk("drain_done_gap", 32'(done_edge - hs_q[1]), 4);

    // back-pressure: ready low for five cycles while valid
    u_if.issue_ready = 1'b0;
    load_prog({48'h444444444444, ins(0,3,5,6)}, 1);
    pulse_start();
    begin
      int k = 0;
      @(negedge clk);
      while (!u_if.issue_valid && k < 20) begin @(negedge clk); k++; end
    end
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(u_if.issue_valid), 1);
      chk("hold_fields", {21'd0, u_if.issue_op, u_if.issue_rd, u_if.issue_rs1, u_if.issue_rs2},
          {21'd0, 2'd0, 3'd3, 3'd5, 3'd6});
      chk("hold_icnt", 32'(instr_count), 0);
      if (i < 4) @(negedge clk);
    end
    u_if.issue_ready = 1'b1;
    wait_end(300);
    chk("hold_icnt_final", 32'(instr_count), 1);

    // illegal opcode, then a restart clears err
    p_bad = {48'h444444444444, ins(9,0,0,0)};
    load_prog(p_bad, 0);
    pulse_start();
    wait_end(100);
    chk("bad_err", {30'd0, done, err}, 1);
    load_prog({48'h444444444444, ins(1,2,3,4)}, 1);
    pulse_start();
    #1 chk("restart_err_clear", {30'd0, done, err}, 0);
    wait_end(300);
    chk("restart_icnt", 32'(instr_count), 1);

    // asynchronous reset while stalled in CHECK on a DIV result
    load_prog(p_raw, 2);
    pulse_start();
    begin
      int k = 0;
      @(negedge clk);
      while (!(st == S_CHECK && instr_count == 16'd1) && k < 100) begin @(negedge clk); k++; end
    end
    chk("stall_state", 32'(st), 32'(S_CHECK));
    rst_n = 1'b0;
    #1 chk_reset("midrun");
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    load_prog(p_raw, 2);
    pulse_start();
    wait_end(300);
    chk("rerun_raw", 32'(raw_stalls), 2);
    chk("rerun_icnt", 32'(instr_count), 2);
    chk("rerun_done", {30'd0, done, err}, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
